tl_uart_arbiter: RTL

//  Two-master TileLink-UL arbiter and sequencer in front of the single UART register slave.

---
 rtl/tl_pkg.sv | 45 ++++
 rtl/rr_arb2.sv | 15 +
 rtl/tl_uart_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared TileLink-UL types, widths and opcodes for the UART arbiter
// Contents: field width constants, channel opcodes, A/D beat structs,
//           arbiter FSM state enum, ack opcode helper.
package tl_pkg;

  localparam int TL_OP_W   = 3;
  localparam int TL_SIZE_W = 3;
  localparam int TL_SRC_W  = 4;
  localparam int TL_ADDR_W = 32;
  localparam int TL_DATA_W = 64;

  localparam logic [TL_OP_W-1:0] TL_PUT_F           = 3'd0;
  localparam logic [TL_OP_W-1:0] TL_GET             = 3'd4;
  localparam logic [TL_OP_W-1:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [TL_OP_W-1:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  typedef struct packed {
    logic [TL_OP_W-1:0]   opcode;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_DATA_W-1:0] data;
  } tl_a_t;

  typedef struct packed {
    logic [TL_OP_W-1:0]   opcode;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_DATA_W-1:0] data;
    logic                 denied;
  } tl_d_t;

  // Response opcode a slave owes for a given request opcode.
  function automatic logic [TL_OP_W-1:0] ack_opcode(input logic [TL_OP_W-1:0] a_opcode);
    return (a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
// Ports: req_i[1:0] requests, last_grant_i previous winner,
//        gnt_valid_o any request present, gnt_o index of the winner.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  assign gnt_valid_o = |req_i;
  // Under contention the master that did not win last time goes first.
  assign gnt_o = (&req_i) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/tl_uart_arbiter.sv
// rtl/tl_uart_arbiter.sv - two-master TileLink-UL arbiter and sequencer for the UART slave
// Ports: clk, rst (async, active high);
//        m0_*/m1_*: requester A channel (a_valid_i, a_ready_o, a_i) and
//                   D channel (d_valid_o, d_ready_i, d_o);
//        s_*: UART side A channel (s_a_valid_o, s_a_ready_i, s_a_o) and
//             D channel (s_d_valid_i, s_d_ready_o, s_d_i).
module tl_uart_arbiter
  import tl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 8
) (
  input  logic  clk,
  input  logic  rst,

  input  logic  m0_a_valid_i,
  output logic  m0_a_ready_o,
  input  tl_a_t m0_a_i,
  output logic  m0_d_valid_o,
  input  logic  m0_d_ready_i,
  output tl_d_t m0_d_o,

  input  logic  m1_a_valid_i,
  output logic  m1_a_ready_o,
  input  tl_a_t m1_a_i,
  output logic  m1_d_valid_o,
  input  logic  m1_d_ready_i,
  output tl_d_t m1_d_o,

  output logic  s_a_valid_o,
  input  logic  s_a_ready_i,
  output tl_a_t s_a_o,
  input  logic  s_d_valid_i,
  output logic  s_d_ready_o,
  input  tl_d_t s_d_i
);

  // One spare bit so the counter can never wrap before reaching TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [TL_ADDR_W-1:0] ADDR_MASK = {{(TL_ADDR_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  arb_state_t       state_q;
  logic             last_grant_q;  // also identifies the owner of the in-flight transaction
  logic [CNT_W-1:0] cnt_q;
  tl_a_t            a_q;
  tl_d_t            d_q;
  logic             s_a_valid_q;
  logic             s_d_ready_q;
  logic             d_valid_q;

  logic  gnt_valid;
  logic  gnt;
  tl_a_t sel_a;
  tl_d_t timeout_d;
  logic  owner_d_ready;

  rr_arb2 u_rr_arb2 (
    .req_i        ({m1_a_valid_i, m0_a_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_o        (gnt)
  );

  assign m0_a_ready_o = (state_q == S_IDLE) && gnt_valid && !gnt;
  assign m1_a_ready_o = (state_q == S_IDLE) && gnt_valid &&  gnt;

  // Winning A beat with the address cut down to the UART offset.
  always_comb begin
    sel_a         = gnt ? m1_a_i : m0_a_i;
    sel_a.address = sel_a.address & ADDR_MASK;
  end

  // Denied response synthesised when the UART stays silent.
  always_comb begin
    timeout_d        = '0;
    timeout_d.opcode = ack_opcode(a_q.opcode);
    timeout_d.size   = a_q.size;
    timeout_d.source = a_q.source;
    timeout_d.denied = 1'b1;
  end

  assign owner_d_ready = last_grant_q ? m1_d_ready_i : m0_d_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a_q          <= '0;
      d_q          <= '0;
      s_a_valid_q  <= 1'b0;
      s_d_ready_q  <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            a_q          <= sel_a;
            last_grant_q <= gnt;
            s_a_valid_q  <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (s_a_ready_i) begin
            s_a_valid_q <= 1'b0;
            s_d_ready_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A real reply takes precedence over a timeout in the same cycle.
          if (s_d_valid_i) begin
            d_q       <= s_d_i;
            d_valid_q <= 1'b1;
            state_q   <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            d_q       <= timeout_d;
            d_valid_q <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          // s_d_ready stays high here so a late UART reply is drained and dropped.
          if (owner_d_ready) begin
            d_valid_q   <= 1'b0;
            s_d_ready_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_a_valid_o = s_a_valid_q;
  assign s_a_o       = a_q;
  assign s_d_ready_o = s_d_ready_q;

  assign m0_d_valid_o = d_valid_q && !last_grant_q;
  assign m1_d_valid_o = d_valid_q &&  last_grant_q;
  assign m0_d_o       = m0_d_valid_o ? d_q : '0;
  assign m1_d_o       = m1_d_valid_o ? d_q : '0;

endmodule
